// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step #(
   parameter int N = 8
) (
   input  logic [N-1:0] rem_in,
   input  logic         dvd_bit,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_out,
   output logic         q_bit
);

   logic [N:0] shifted;
   logic [N:0] diff;

   // The restored remainder is always below the divisor, so N bits hold it between steps;
   // the shifted trial value needs N+1 bits, and bit N of the difference is the sign.
   always_comb begin
      shifted = {rem_in, dvd_bit};
      diff    = shifted - {1'b0, divisor};
      q_bit   = ~diff[N];
      rem_out = diff[N] ? shifted[N-1:0] : diff[N-1:0];
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential N-cycle restoring divider with start/ready/busy/done handshake.
// Define DIV_SIGNED_EN to add the signed_op port for two's-complement division.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
`ifdef DIV_SIGNED_EN
   input  logic         signed_op,
`endif
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = $clog2(N);

   div_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [N-1:0]  dvd_q, dvd_d;
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  quotient_q, quotient_d;
   logic [N-1:0]  remainder_q, remainder_d;
   logic          zero_q, zero_d;
   logic          dbz_q, dbz_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [N-1:0]  step_rem;
   logic          step_q;
   logic [N-1:0]  q_raw, r_raw, q_res, r_res;
   logic [N-1:0]  dvd_in, dvs_in;

   div_step #(.N(N)) u_step (
      .rem_in  (rem_q),
      .dvd_bit (dvd_q[N-1]),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // dvd_q shifts the dividend out of its top while quotient bits enter at the bottom.
   assign q_raw = {dvd_q[N-2:0], step_q};
   assign r_raw = step_rem;

`ifdef DIV_SIGNED_EN
   logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

   always_comb begin
      dvd_in  = (signed_op && dividend[N-1]) ? -dividend : dividend;
      dvs_in  = (signed_op && divisor[N-1]) ? -divisor : divisor;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      if (ready_q && start && divisor != '0) begin
         neg_q_d = signed_op && (dividend[N-1] ^ divisor[N-1]);
         neg_r_d = signed_op && dividend[N-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else begin
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
      end
   end

   // Magnitude 2^(N-1) negated wraps back onto itself, giving the -2^(N-1)/-1 result.
   assign q_res = neg_q_q ? -q_raw : q_raw;
   assign r_res = neg_r_q ? -r_raw : r_raw;
`else
   assign dvd_in = dividend;
   assign dvs_in = divisor;
   assign q_res  = q_raw;
   assign r_res  = r_raw;
`endif

   // A zero divisor still spends one RUN cycle so done arrives one edge after accept.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      zero_d      = zero_q;
      dbz_d       = dbz_q;
      case (state_q)
         RUN: begin
            rem_d = step_rem;
            dvd_d = q_raw;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
               if (zero_q) begin
                  quotient_d  = '1;
                  remainder_d = dvd_q;
                  dbz_d       = 1'b1;
               end else begin
                  quotient_d  = q_res;
                  remainder_d = r_res;
               end
            end
         end
         default: begin
            state_d = IDLE;
            if (start) begin
               state_d = RUN;
               rem_d   = '0;
               dvs_d   = dvs_in;
               if (divisor == '0) begin
                  zero_d = 1'b1;
                  cnt_d  = '0;
                  dvd_d  = dividend;
               end else begin
                  zero_d = 1'b0;
                  cnt_d  = CW'(N - 1);
                  dvd_d  = dvd_in;
                  dbz_d  = 1'b0;
               end
            end
         end
      endcase
      ready_d = (state_d != RUN);
      busy_d  = (state_d == RUN);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         zero_q      <= 1'b0;
         dbz_q       <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         zero_q      <= zero_d;
         dbz_q       <= dbz_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ready       = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed table, handshake/reset sequences and random sweeps at N=4/8/16.
module tb_seq_restoring_divider;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        s8 = 1'b0, s4 = 1'b0, s16 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [7:0]  q8, r8;
   logic [3:0]  q4, r4;
   logic [15:0] q16, r16;
   logic        rdy8, bsy8, dn8, z8;
   logic        rdy4, bsy4, dn4, z4;
   logic        rdy16, bsy16, dn16, z16;
`ifdef DIV_SIGNED_EN
   logic        sop8 = 1'b0;
`endif

   seq_restoring_divider #(.N(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(s8), .dividend(a8), .divisor(b8),
`ifdef DIV_SIGNED_EN
      .signed_op(sop8),
`endif
      .ready(rdy8), .busy(bsy8), .done(dn8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
   );

   seq_restoring_divider #(.N(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(s4), .dividend(a4), .divisor(b4),
`ifdef DIV_SIGNED_EN
      .signed_op(1'b0),
`endif
      .ready(rdy4), .busy(bsy4), .done(dn4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
   );

   seq_restoring_divider #(.N(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(s16), .dividend(a16), .divisor(b16),
`ifdef DIV_SIGNED_EN
      .signed_op(1'b0),
`endif
      .ready(rdy16), .busy(bsy16), .done(dn16), .quotient(q16), .remainder(r16), .div_by_zero(z16)
   );

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
      int         lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic rdy_of(input int w);
      case (w)
         4:       return rdy4;
         16:      return rdy16;
         default: return rdy8;
      endcase
   endfunction

   function automatic logic dn_of(input int w);
      case (w)
         4:       return dn4;
         16:      return dn16;
         default: return dn8;
      endcase
   endfunction

   task automatic drive(input int w, input logic [15:0] a, input logic [15:0] b, input logic st);
      case (w)
         4:       begin a4 = a[3:0]; b4 = b[3:0]; s4 = st; end
         16:      begin a16 = a; b16 = b; s16 = st; end
         default: begin a8 = a[7:0]; b8 = b[7:0]; s8 = st; end
      endcase
   endtask

   task automatic read_res(input int w, output logic [15:0] q, output logic [15:0] r, output logic z);
      case (w)
         4:       begin q = {12'd0, q4}; r = {12'd0, r4}; z = z4; end
         16:      begin q = q16; r = r16; z = z16; end
         default: begin q = {8'd0, q8}; r = {8'd0, r8}; z = z8; end
      endcase
   endtask

   // One full operation: wait for ready, pulse start, count edges from accept until done.
   task automatic opn(input int w, input logic [15:0] a, input logic [15:0] b, input logic sgn,
                      output logic [15:0] q, output logic [15:0] r, output logic z, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!rdy_of(w) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
`ifdef DIV_SIGNED_EN
      sop8 = sgn;
`endif
      drive(w, a, b, 1'b1);
      @(posedge clk); #1;
      drive(w, a, b, 1'b0);
      lat = 0;
      while (!dn_of(w) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      read_res(w, q, r, z);
   endtask

   // Reference: plain integer division; zero divisor gives all ones and the dividend back.
   function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b, input logic sgn,
                                 output logic [15:0] q, output logic [15:0] r, output logic z);
      logic [15:0] mask;
      int sa, sb;
      mask = (16'h1 << w) - 16'h1;
      if (w == 16) mask = 16'hffff;
      if (b == 16'd0) begin
         q = mask; r = a; z = 1'b1;
      end else if (sgn) begin
         sa = $signed(a[7:0]);
         sb = $signed(b[7:0]);
         q = 16'(sa / sb) & mask;
         r = 16'(sa % sb) & mask;
         z = 1'b0;
      end else begin
         q = a / b; r = a % b; z = 1'b0;
      end
   endfunction

   task automatic check_op(input string name, input int w, input logic [15:0] a, input logic [15:0] b,
                           input logic sgn, input logic [15:0] q, input logic [15:0] r, input logic z,
                           input int lat);
      logic [15:0] eq, er;
      logic ez;
      int el;
      model(w, a, b, sgn, eq, er, ez);
      el = (b == 16'd0) ? 1 : w;
      checks++;
      if (q == eq && r == er && z == ez && lat == el) passed++;
      else $display("FAIL %s N=%0d %0d/%0d: got q=%0d r=%0d z=%0d lat=%0d, expected q=%0d r=%0d z=%0d lat=%0d",
                    name, w, a, b, q, r, z, lat, eq, er, ez, el);
   endtask

   logic [15:0] rq, rr, ra, rb;
   logic        rz;
   int          rlat;
   int          done_seen;

   initial begin
      vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 8};
      vecs[1] = '{8'd13,  8'd0,   8'd255, 8'd13,  1'b1, 1};
      vecs[2] = '{8'd255, 8'd3,   8'd85,  8'd0,   1'b0, 8};
      vecs[3] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8};
      vecs[4] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
      vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
      vecs[6] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
      vecs[7] = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1, 1};
      vecs[8] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 8};
      vecs[9] = '{8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 8};

      repeat (2) @(negedge clk);
      check("reset_quotient", q8, 0);
      check("reset_remainder", r8, 0);
      check("reset_done", dn8, 0);
      check("reset_busy", bsy8, 0);
      check("reset_dbz", z8, 0);
      check("reset_ready", rdy8, 1);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         opn(8, {8'd0, vecs[i].a}, {8'd0, vecs[i].b}, 1'b0, rq, rr, rz, rlat);
         check($sformatf("vec%0d_quotient", i), rq, vecs[i].q);
         check($sformatf("vec%0d_remainder", i), rr, vecs[i].r);
         check($sformatf("vec%0d_dbz", i), rz, vecs[i].z);
         check($sformatf("vec%0d_latency", i), rlat, vecs[i].lat);
      end

      // Start during RUN is ignored; start held in DONE is accepted without a bubble.
      @(negedge clk);
      a8 = 8'd100; b8 = 8'd10; s8 = 1'b1;
      @(posedge clk); #1;
      s8 = 1'b0;
      check("b2b_busy_after_accept", bsy8, 1);
      repeat (2) begin @(posedge clk); #1; end
      a8 = 8'd50; b8 = 8'd5; s8 = 1'b1;
      @(posedge clk); #1;
      s8 = 1'b0;
      check("b2b_busy_ignore", bsy8, 1);
      rlat = 3;
      while (!dn8 && rlat < 40) begin @(posedge clk); #1; rlat++; end
      check("b2b_first_latency", rlat, 8);
      check("b2b_first_quotient", q8, 10);
      check("b2b_first_remainder", r8, 0);
      a8 = 8'd9; b8 = 8'd2; s8 = 1'b1;
      @(posedge clk); #1;
      s8 = 1'b0;
      check("b2b_no_bubble_busy", bsy8, 1);
      check("b2b_no_bubble_done", dn8, 0);
      check("b2b_no_bubble_ready", rdy8, 0);
      rlat = 0;
      while (!dn8 && rlat < 40) begin @(posedge clk); #1; rlat++; end
      check("b2b_second_latency", rlat, 8);
      check("b2b_second_quotient", q8, 4);
      check("b2b_second_remainder", r8, 1);
      @(posedge clk); #1;
      check("done_single_pulse", dn8, 0);

      // Reset in the middle of an operation.
      @(negedge clk);
      a8 = 8'd255; b8 = 8'd3; s8 = 1'b1;
      @(posedge clk); #1;
      s8 = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("midrst_quotient", q8, 0);
      check("midrst_remainder", r8, 0);
      check("midrst_ready", rdy8, 1);
      check("midrst_busy", bsy8, 0);
      check("midrst_done", dn8, 0);
      check("midrst_dbz", z8, 0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (dn8) done_seen++;
      end
      check("midrst_no_done_pulse", done_seen, 0);
      opn(8, 16'd255, 16'd3, 1'b0, rq, rr, rz, rlat);
      check("midrst_redo_quotient", rq, 85);
      check("midrst_redo_remainder", rr, 0);
      check("midrst_redo_latency", rlat, 8);

`ifdef DIV_SIGNED_EN
      opn(8, 16'h00f9, 16'h0002, 1'b1, rq, rr, rz, rlat);
      check("signed_m7_2_quotient", rq, 16'h00fd);
      check("signed_m7_2_remainder", rr, 16'h00ff);
      check("signed_m7_2_latency", rlat, 8);
      opn(8, 16'h0080, 16'h00ff, 1'b1, rq, rr, rz, rlat);
      check("signed_wrap_quotient", rq, 16'h0080);
      check("signed_wrap_remainder", rr, 0);
      check("signed_wrap_dbz", rz, 0);
      opn(8, 16'h00fb, 16'h0000, 1'b1, rq, rr, rz, rlat);
      check("signed_dbz_quotient", rq, 16'h00ff);
      check("signed_dbz_remainder", rr, 16'h00fb);
      check("signed_dbz_flag", rz, 1);
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom_range(0, 255));
         rb = (i % 16 == 0) ? 16'd0 : 16'($urandom_range(0, 255));
         opn(8, ra, rb, 1'b1, rq, rr, rz, rlat);
         check_op("rand_signed8", 8, ra, rb, 1'b1, rq, rr, rz, rlat);
      end
`endif

      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom_range(0, 255));
         rb = (i % 10 == 0) ? 16'd0 : 16'($urandom_range(0, 255));
         opn(8, ra, rb, 1'b0, rq, rr, rz, rlat);
         check_op("rand8", 8, ra, rb, 1'b0, rq, rr, rz, rlat);
      end

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            opn(4, 16'(a), 16'(b), 1'b0, rq, rr, rz, rlat);
            check_op("exh4", 4, 16'(a), 16'(b), 1'b0, rq, rr, rz, rlat);
         end
      end

      for (int i = 0; i < 1500; i++) begin
         ra = 16'($urandom_range(0, 65535));
         case (i % 8)
            0:       rb = 16'd0;
            1:       rb = 16'($urandom_range(1, 15));
            2:       rb = 16'hffff;
            default: rb = 16'($urandom_range(0, 65535));
         endcase
         opn(16, ra, rb, 1'b0, rq, rr, rz, rlat);
         check_op("rand16", 16, ra, rb, 1'b0, rq, rr, rz, rlat);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
